// File: rtl/uart_link_pkg.sv
// Types and character constants shared by the UART line framer and its idle timer.
package uart_link_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      DISCARD  = 2'd2,
      DISPATCH = 2'd3
   } framer_state_t;

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/uart_idle_timer.sv
// Counts consecutive idle cycles while running; flags the edge on which the
// count reaches TIMEOUT_CYCLES so the owner can act on that same edge.
module uart_idle_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expired
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_run && (r_count != TW'(TIMEOUT_CYCLES))) begin
         r_count <= r_count + TW'(1);
      end
   end

   // High in the cycle whose closing edge takes the count to TIMEOUT_CYCLES.
   assign o_expired = i_run && !i_clear && (r_count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_framer.sv
// Collects received bytes into a fixed-length line window and dispatches each
// well-formed LF-terminated line to the command checker with a one-cycle pulse.
module uart_cmd_framer
   import uart_link_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int CHARACTER_COUNT = 10,
   parameter int TIMEOUT_CYCLES  = 100000
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset_n,
   input  logic [DATA_WIDTH-1:0]                 i_rx_data,
   input  logic                                  i_rx_valid,
   output logic [DATA_WIDTH*CHARACTER_COUNT-1:0] o_sr_data,
   output logic                                  o_cmd_ena,
   output logic                                  o_frame_error,
   output logic                                  o_busy
);

   localparam int W  = DATA_WIDTH * CHARACTER_COUNT;
   localparam int CW = $clog2(CHARACTER_COUNT + 1);

   framer_state_t   r_state;
   logic [W-1:0]    r_sr;
   logic [CW-1:0]   r_count;
   logic            r_cmd;
   logic            r_err;

   logic            w_is_lf;
   logic            w_is_cr;
   logic            w_data;
   logic            w_lf;
   logic            w_full;
   logic            w_line_active;
   logic            w_expired;

   assign w_is_lf       = (i_rx_data == DATA_WIDTH'(ASCII_LF));
   assign w_is_cr       = (i_rx_data == DATA_WIDTH'(ASCII_CR));
   assign w_data        = i_rx_valid && !w_is_lf && !w_is_cr;
   assign w_lf          = i_rx_valid && w_is_lf;
   assign w_full        = (r_count == CW'(CHARACTER_COUNT));
   assign w_line_active = (r_state == COLLECT) || (r_state == DISCARD);

   uart_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_clear    (i_rx_valid || !w_line_active),
      .i_run      (w_line_active),
      .o_expired  (w_expired)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
         r_sr    <= '0;
         r_count <= '0;
         r_cmd   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_cmd <= 1'b0;
         r_err <= 1'b0;
         unique case (r_state)
            // DISPATCH shares IDLE rules so a byte arriving during the pulse is kept.
            IDLE, DISPATCH: begin
               r_state <= IDLE;
               if (w_data) begin
                  r_sr    <= {{(W-DATA_WIDTH){1'b0}}, i_rx_data};
                  r_count <= CW'(1);
                  r_state <= COLLECT;
               end
            end
            COLLECT: begin
               if (w_data) begin
                  if (w_full) begin
                     r_err   <= 1'b1;
                     r_state <= DISCARD;
                  end else begin
                     r_sr    <= {r_sr[W-DATA_WIDTH-1:0], i_rx_data};
                     r_count <= r_count + CW'(1);
                  end
               end else if (w_lf) begin
                  if (w_full) begin
                     r_cmd   <= 1'b1;
                     r_state <= DISPATCH;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= IDLE;
                  end
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end
            end
            DISCARD: begin
               if (w_lf || w_expired) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_sr_data     = r_sr;
   assign o_cmd_ena     = r_cmd;
   assign o_frame_error = r_err;
   assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: a line-level queue model is checked every
// cycle, and literal expectations pin window contents, pulse counts and timing.
module tb_uart_cmd_framer;

   localparam int DW = 8;
   localparam int CC = 10;
   localparam int TO = 16;
   localparam int W  = DW * CC;

   logic          i_clk      = 1'b0;
   logic          i_reset_n  = 1'b0;
   logic          i_rx_valid = 1'b0;
   logic [DW-1:0] i_rx_data  = '0;
   logic [W-1:0]  o_sr_data;
   logic          o_cmd_ena;
   logic          o_frame_error;
   logic          o_busy;

   uart_cmd_framer #(
      .DATA_WIDTH      (DW),
      .CHARACTER_COUNT (CC),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_rx_data     (i_rx_data),
      .i_rx_valid    (i_rx_valid),
      .o_sr_data     (o_sr_data),
      .o_cmd_ena     (o_cmd_ena),
      .o_frame_error (o_frame_error),
      .o_busy        (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_cmd = 0;
   int           n_err = 0;
   logic [W-1:0] cap_sr = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Line-level model: the current line is a queue of characters.
   logic [DW-1:0] m_buf[$];
   bit            m_col  = 1'b0;
   bit            m_dis  = 1'b0;
   int            m_idle = 0;
   logic          e_cmd  = 1'b0;
   logic          e_err  = 1'b0;
   logic          e_busy = 1'b0;
   logic [W-1:0]  e_sr   = '0;

   function automatic logic [W-1:0] window();
      logic [W-1:0] v;
      v = '0;
      foreach (m_buf[i]) v = {v[W-DW-1:0], m_buf[i]};
      return v;
   endfunction

   always @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         m_buf.delete();
         m_col = 1'b0; m_dis = 1'b0; m_idle = 0;
         e_cmd = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_sr = '0;
      end else begin
         e_cmd = 1'b0;
         e_err = 1'b0;
         if (i_rx_valid) begin
            m_idle = 0;
            if (i_rx_data != 8'h0D) begin
               if (!m_col && !m_dis) begin
                  if (i_rx_data != 8'h0A) begin
                     m_buf.delete();
                     m_buf.push_back(i_rx_data);
                     m_col = 1'b1;
                  end
               end else if (m_col) begin
                  if (i_rx_data == 8'h0A) begin
                     m_col = 1'b0;
                     if (m_buf.size() == CC) e_cmd = 1'b1;
                     else e_err = 1'b1;
                  end else if (m_buf.size() == CC) begin
                     m_col = 1'b0; m_dis = 1'b1; e_err = 1'b1;
                  end else begin
                     m_buf.push_back(i_rx_data);
                  end
               end else if (i_rx_data == 8'h0A) begin
                  m_dis = 1'b0;
               end
            end
         end else if (m_col || m_dis) begin
            m_idle++;
            if (m_idle == TO) begin
               e_err = m_col;
               m_col = 1'b0; m_dis = 1'b0; m_idle = 0;
            end
         end
         e_busy = m_col || m_dis || e_cmd;
         e_sr   = window();
      end
   end

   always @(negedge i_clk) begin
      check("cmd_ena", W'(o_cmd_ena), W'(e_cmd));
      check("frame_error", W'(o_frame_error), W'(e_err));
      check("busy", W'(o_busy), W'(e_busy));
      check("sr_data", o_sr_data, e_sr);
      if (o_cmd_ena) begin
         n_cmd++;
         cap_sr = o_sr_data;
      end
      if (o_frame_error) n_err++;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      @(posedge i_clk);
      #1;
      i_rx_valid = 1'b0;
      idle(gap);
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
   endtask

   task automatic send_line(input string s, input bit cr, input int gap);
      send_str(s, gap);
      if (cr) send_byte(8'h0D, gap);
      send_byte(8'h0A, gap);
   endtask

   task automatic clr();
      n_cmd = 0;
      n_err = 0;
   endtask

   initial begin
      int k;
      repeat (2) @(negedge i_clk);
      check("rst_sr", o_sr_data, '0);
      check("rst_cmd", W'(o_cmd_ena), '0);
      check("rst_err", W'(o_frame_error), '0);
      check("rst_busy", W'(o_busy), '0);
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      idle(2);

      clr();
      send_line("SW: 0x1A2F", 1'b0, 1);
      idle(3);
      check("sw_cmd_cnt", W'(n_cmd), W'(1));
      check("sw_err_cnt", W'(n_err), W'(0));
      check("sw_window", cap_sr, 80'h53573A20307831413246);
      check("sw_payload", W'(cap_sr[31:0]), W'(32'h31413246));

      clr();
      send_line("BT: 0x0015", 1'b1, 1);
      idle(3);
      check("bt_cmd_cnt", W'(n_cmd), W'(1));
      check("bt_last_chr", W'(cap_sr[7:0]), W'(8'h35));

      clr();
      send_line("SW: 0x1A2", 1'b0, 1);
      idle(2);
      check("short_err_cnt", W'(n_err), W'(1));
      check("short_cmd_cnt", W'(n_cmd), W'(0));
      check("short_busy", W'(o_busy), '0);

      clr();
      send_line("SW: 0x1A2F3", 1'b0, 1);
      idle(3);
      send_line("BT: 0x001F", 1'b0, 1);
      idle(3);
      check("long_err_cnt", W'(n_err), W'(1));
      check("long_cmd_cnt", W'(n_cmd), W'(1));
      check("long_next_win", cap_sr, 80'h42543A20307830303146);

      // 16 idle cycles elapse after the last byte, then the pulse is visible.
      clr();
      send_str("SW: ", 1);
      send_byte(8'h30, 0);
      k = 0;
      for (int c = 1; c <= 40 && k == 0; c++) begin
         @(negedge i_clk);
         if (o_frame_error) k = c;
      end
      check("timeout_latency", W'(k), W'(TO + 1));
      @(posedge i_clk);
      #1;
      idle(2);
      send_line("SW: 0x00FF", 1'b0, 1);
      idle(3);
      check("timeout_err_cnt", W'(n_err), W'(1));
      check("after_to_cmd_cnt", W'(n_cmd), W'(1));

      clr();
      send_str("SW: 0x1A2F3", 1);
      idle(40);
      check("discard_to_err_cnt", W'(n_err), W'(1));
      check("discard_to_busy", W'(o_busy), '0);

      clr();
      send_line("SW: 0x1A2F", 1'b0, 0);
      send_line("BT: 0x0015", 1'b0, 0);
      idle(3);
      check("b2b_cmd_cnt", W'(n_cmd), W'(2));
      check("b2b_last_win", cap_sr, 80'h42543A20307830303135);

      clr();
      send_byte(8'h0A, 1);
      send_byte(8'h0D, 1);
      send_byte(8'h0A, 1);
      idle(2);
      check("empty_pulses", W'(n_cmd + n_err), '0);
      check("empty_busy", W'(o_busy), '0);

      clr();
      send_str("SW: 0x", 1);
      #2;
      i_reset_n = 1'b0;
      #1;
      check("async_rst_sr", o_sr_data, '0);
      check("async_rst_busy", W'(o_busy), '0);
      @(posedge i_clk);
      #1;
      idle(2);
      i_reset_n = 1'b1;
      idle(2);
      send_line("1A2F", 1'b0, 1);
      idle(3);
      check("rst_tail_err_cnt", W'(n_err), W'(1));
      check("rst_tail_cmd_cnt", W'(n_cmd), W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
